// File: rtl/mb_sequencer_if.sv
// Math Box sequencer bus: command strobe, microword fields from ROM, and status back to the CPU.
interface mb_sequencer_if;
   logic       begin_cmd;
   logic [7:0] start_addr;
   logic       u_stop;
   logic       u_jump;
   logic       u_cond;
   logic [7:0] u_jaddr;
   logic       alu_flag;
   logic [7:0] pc;
   logic       alu_en;
   logic       busy;
   logic       done;
   logic       timeout;

   modport master (
      output begin_cmd, start_addr, u_stop, u_jump, u_cond, u_jaddr, alu_flag,
      input  pc, alu_en, busy, done, timeout
   );

   modport slave (
      input  begin_cmd, start_addr, u_stop, u_jump, u_cond, u_jaddr, alu_flag,
      output pc, alu_en, busy, done, timeout
   );
endinterface

// File: rtl/mb_sequencer.sv
// Math Box microprogram sequencer: walks the microcode ROM from a decoded start address
// until a STOP word executes, with jump handling and a watchdog abort.
module mb_sequencer #(
   parameter int WDOG_MAX = 1023
) (
   input  logic          clk,
   input  logic          reset,
   mb_sequencer_if.slave mb
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [9:0] WDOG_LIMIT = 10'(WDOG_MAX);

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_pc;
   logic [7:0] w_pc_next;
   logic [9:0] r_wdog;
   logic [9:0] w_wdog_next;
   logic [9:0] w_wdog_inc;
   logic       r_done;
   logic       w_done_next;
   logic       r_timeout;
   logic       w_timeout_next;
   logic       w_jump_taken;

   assign w_wdog_inc   = r_wdog + 10'd1;
   assign w_jump_taken = mb.u_jump && (!mb.u_cond || mb.alu_flag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_pc      <= 8'h00;
         r_wdog    <= 10'd0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_wdog    <= w_wdog_next;
         r_done    <= w_done_next;
         r_timeout <= w_timeout_next;
      end
   end

   // A new command always wins; STOP outranks the watchdog so a program ending
   // exactly on the limit still completes normally.
   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_wdog_next    = r_wdog;
      w_done_next    = 1'b0;
      w_timeout_next = r_timeout;
      case (r_state)
         ST_IDLE: begin
            if (mb.begin_cmd) begin
               w_pc_next      = mb.start_addr;
               w_wdog_next    = 10'd0;
               w_timeout_next = 1'b0;
               w_state_next   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (mb.begin_cmd) begin
               w_pc_next      = mb.start_addr;
               w_wdog_next    = 10'd0;
               w_timeout_next = 1'b0;
            end else if (mb.u_stop) begin
               w_state_next = ST_IDLE;
               w_done_next  = 1'b1;
            end else if (w_wdog_inc == WDOG_LIMIT) begin
               w_wdog_next    = w_wdog_inc;
               w_timeout_next = 1'b1;
               w_state_next   = ST_IDLE;
            end else begin
               w_wdog_next = w_wdog_inc;
               w_pc_next   = w_jump_taken ? mb.u_jaddr : r_pc + 8'd1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign mb.pc      = r_pc;
   assign mb.busy    = (r_state == ST_RUN);
   assign mb.alu_en  = (r_state == ST_RUN);
   assign mb.done    = r_done;
   assign mb.timeout = r_timeout;

   a_done_timeout_exclusive : assert property (
      @(posedge clk) disable iff (reset) !(r_done && r_timeout)
   );

   a_done_only_when_idle : assert property (
      @(posedge clk) disable iff (reset) r_done |-> (r_state == ST_IDLE)
   );

endmodule

// File: tb/tb_mb_sequencer.sv
// Randomized and directed bench for mb_sequencer against a program-walking reference model.
module tb_mb_sequencer;

   localparam int WDOG = 15;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mb_sequencer_if mb ();

   mb_sequencer #(.WDOG_MAX(WDOG)) dut (
      .clk   (clk),
      .reset (reset),
      .mb    (mb)
   );

   bit         rom_stop  [256];
   bit         rom_jump  [256];
   bit         rom_cond  [256];
   logic [7:0] rom_jaddr [256];

   assign mb.u_stop  = rom_stop[mb.pc];
   assign mb.u_jump  = rom_jump[mb.pc];
   assign mb.u_cond  = rom_cond[mb.pc];
   assign mb.u_jaddr = rom_jaddr[mb.pc];

   int         n_checks = 0;
   int         n_fail   = 0;
   bit         flags    [64];
   logic [7:0] exp_pc   [64];
   int         exp_len;
   bit         exp_stop;
   bit         last_timeout;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void clear_rom();
      for (int a = 0; a < 256; a++) begin
         rom_stop[a]  = 1'b0;
         rom_jump[a]  = 1'b0;
         rom_cond[a]  = 1'b0;
         rom_jaddr[a] = 8'h00;
      end
   endfunction

   function automatic void random_rom();
      for (int a = 0; a < 256; a++) begin
         rom_stop[a]  = ($urandom_range(0, 7) == 0);
         rom_jump[a]  = ($urandom_range(0, 3) == 0);
         rom_cond[a]  = 1'($urandom_range(0, 1));
         rom_jaddr[a] = 8'($urandom_range(0, 255));
      end
   endfunction

   // Reference: list the addresses the program executes, given the flag seen on each cycle.
   function automatic void walk(input logic [7:0] start);
      logic [7:0] p;
      p        = start;
      exp_len  = 0;
      exp_stop = 1'b0;
      for (int i = 0; i < 64; i++) begin
         exp_pc[i] = p;
         exp_len   = i + 1;
         if (rom_stop[p]) begin
            exp_stop = 1'b1;
            break;
         end
         if (i + 1 == WDOG) break;
         if (rom_jump[p] && (!rom_cond[p] || flags[i])) p = rom_jaddr[p];
         else p = p + 8'd1;
      end
   endfunction

   task automatic run_cmd(input logic [7:0] start, input int fmode, input string name);
      for (int i = 0; i < 64; i++)
         flags[i] = (fmode == 0) ? 1'b0 : (fmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      walk(start);
      mb.begin_cmd  = 1'b1;
      mb.start_addr = start;
      tick();
      mb.begin_cmd = 1'b0;
      check_val({name, "_first_timeout"}, 32'(mb.timeout), 32'd0);
      check_val({name, "_first_done"}, 32'(mb.done), 32'd0);
      for (int i = 0; i < exp_len; i++) begin
         mb.alu_flag = flags[i];
         check_val({name, "_pc"}, 32'(mb.pc), 32'(exp_pc[i]));
         check_val({name, "_alu_en"}, 32'(mb.alu_en), 32'd1);
         check_val({name, "_busy"}, 32'(mb.busy), 32'd1);
         tick();
      end
      check_val({name, "_end_busy"}, 32'(mb.busy), 32'd0);
      check_val({name, "_end_alu_en"}, 32'(mb.alu_en), 32'd0);
      check_val({name, "_end_done"}, 32'(mb.done), 32'(exp_stop));
      check_val({name, "_end_timeout"}, 32'(mb.timeout), 32'(!exp_stop));
      check_val({name, "_end_pc_hold"}, 32'(mb.pc), 32'(exp_pc[exp_len-1]));
      last_timeout = !exp_stop;
      $display("CMD %s start=%02h words=%0d end=%s", name, start, exp_len,
               exp_stop ? "stop" : "watchdog");
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset         = 1'b1;
      mb.begin_cmd  = 1'b0;
      mb.start_addr = 8'h00;
      mb.alu_flag   = 1'b0;
      last_timeout  = 1'b0;
      clear_rom();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_pc", 32'(mb.pc), 32'h00);
      check_val("rst_busy", 32'(mb.busy), 32'd0);
      check_val("rst_alu_en", 32'(mb.alu_en), 32'd0);
      check_val("rst_done", 32'(mb.done), 32'd0);
      check_val("rst_timeout", 32'(mb.timeout), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check_val("idle_busy", 32'(mb.busy), 32'd0);
      $display("CMD reset pc=%02h busy=%0d", mb.pc, mb.busy);

      clear_rom();
      rom_stop[8'h23] = 1'b1;
      run_cmd(8'h20, 0, "linear");

      clear_rom();
      rom_jump[8'h41] = 1'b1; rom_jaddr[8'h41] = 8'h7E;
      rom_stop[8'h7F] = 1'b1;
      run_cmd(8'h41, 0, "ujump");

      clear_rom();
      rom_jump[8'hB8] = 1'b1; rom_cond[8'hB8] = 1'b1; rom_jaddr[8'hB8] = 8'hD9;
      rom_stop[8'hB9] = 1'b1; rom_stop[8'hD9] = 1'b1;
      run_cmd(8'hB8, 0, "cjump_f0");
      check_val("cjump_f0_last", 32'(exp_pc[exp_len-1]), 32'hB9);
      run_cmd(8'hB8, 1, "cjump_f1");
      check_val("cjump_f1_last", 32'(exp_pc[exp_len-1]), 32'hD9);

      clear_rom();
      rom_stop[8'h01] = 1'b1;
      run_cmd(8'hFE, 2, "wrap");

      // Restart on a STOP word: the new command wins and no done is produced.
      clear_rom();
      rom_stop[8'h51] = 1'b1;
      rom_stop[8'h2D] = 1'b1;
      mb.begin_cmd = 1'b1; mb.start_addr = 8'h50;
      tick();
      mb.begin_cmd = 1'b0;
      tick();
      check_val("restart_pc_stop", 32'(mb.pc), 32'h51);
      mb.begin_cmd = 1'b1; mb.start_addr = 8'h2C;
      tick();
      mb.begin_cmd = 1'b0;
      check_val("restart_pc", 32'(mb.pc), 32'h2C);
      check_val("restart_busy", 32'(mb.busy), 32'd1);
      check_val("restart_done", 32'(mb.done), 32'd0);
      tick();
      check_val("restart_pc2", 32'(mb.pc), 32'h2D);
      check_val("restart_done2", 32'(mb.done), 32'd0);
      tick();
      check_val("restart_end_busy", 32'(mb.busy), 32'd0);
      check_val("restart_end_done", 32'(mb.done), 32'd1);
      $display("CMD restart start=2c pc=%02h done=%0d", mb.pc, mb.done);

      clear_rom();
      rom_jump[8'h60] = 1'b1; rom_jaddr[8'h60] = 8'h60;
      run_cmd(8'h60, 0, "selfjump");
      rom_stop[8'h60] = 1'b1;
      run_cmd(8'h60, 0, "after_wdog");

      // Asynchronous reset while running a runaway program.
      rom_stop[8'h60] = 1'b0;
      mb.begin_cmd = 1'b1; mb.start_addr = 8'h60;
      tick();
      mb.begin_cmd = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      check_val("midrst_pc", 32'(mb.pc), 32'h00);
      check_val("midrst_busy", 32'(mb.busy), 32'd0);
      check_val("midrst_alu_en", 32'(mb.alu_en), 32'd0);
      check_val("midrst_done", 32'(mb.done), 32'd0);
      check_val("midrst_timeout", 32'(mb.timeout), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check_val("postrst_busy", 32'(mb.busy), 32'd0);
      check_val("postrst_done", 32'(mb.done), 32'd0);
      $display("CMD midrun_reset pc=%02h busy=%0d", mb.pc, mb.busy);
      last_timeout = 1'b0;

      for (int n = 0; n < 40; n++) begin
         random_rom();
         run_cmd(8'($urandom_range(0, 255)), 2, "rand");
         if ($urandom_range(0, 1) == 1) begin
            tick();
            check_val("gap_done", 32'(mb.done), 32'd0);
            check_val("gap_busy", 32'(mb.busy), 32'd0);
            check_val("gap_timeout", 32'(mb.timeout), 32'(last_timeout));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
